// File: rtl/add_sub_16b_pkg.sv
// add_sub_16b_pkg
//   Shared constants for the 16-bit adder/subtractor slice.
//   ADDSUB_W : datapath width in bits (fixed at 16).
package add_sub_16b_pkg;

  localparam int ADDSUB_W = 16;

endpackage : add_sub_16b_pkg

// File: rtl/add_sub_16b_if.sv
// add_sub_16b_if
//   Operand/result bundle for add_sub_16b.
//   Signals:
//     AddSub_i_A, AddSub_i_B : operands
//     AddSub_i_fSub          : 0 = add, 1 = subtract
//     AddSub_i_valid         : operands valid this cycle
//     AddSub_o_S             : registered result
//     AddSub_o_C             : registered carry-out (inverted borrow when subtracting)
//     AddSub_o_V             : registered signed-overflow flag
//     AddSub_o_valid         : result registers were loaded on the last edge
//   Handshake: valid-only, no ready. A beat is taken on every rising edge
//   where AddSub_i_valid = 1; AddSub_o_valid is high for exactly the cycle
//   after each taken beat. There is no backpressure.
//   Modports:
//     master : operand source / result sink (testbench or parent block)
//     slave  : the adder/subtractor itself
interface add_sub_16b_if;
  import add_sub_16b_pkg::*;

  logic [ADDSUB_W-1:0] AddSub_i_A;
  logic [ADDSUB_W-1:0] AddSub_i_B;
  logic                AddSub_i_fSub;
  logic                AddSub_i_valid;
  logic [ADDSUB_W-1:0] AddSub_o_S;
  logic                AddSub_o_C;
  logic                AddSub_o_V;
  logic                AddSub_o_valid;

  modport master (
    output AddSub_i_A,
    output AddSub_i_B,
    output AddSub_i_fSub,
    output AddSub_i_valid,
    input  AddSub_o_S,
    input  AddSub_o_C,
    input  AddSub_o_V,
    input  AddSub_o_valid
  );

  modport slave (
    input  AddSub_i_A,
    input  AddSub_i_B,
    input  AddSub_i_fSub,
    input  AddSub_i_valid,
    output AddSub_o_S,
    output AddSub_o_C,
    output AddSub_o_V,
    output AddSub_o_valid
  );

endinterface : add_sub_16b_if

// File: rtl/add_sub_16b_full_adder.sv
// full_adder
//   One-bit full adder cell for the ripple chain.
//   Ports:
//     a, b, cin : addend bits and carry-in
//     s         : sum bit
//     cout      : carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/add_sub_16b.sv
// add_sub_16b
//   Registered 16-bit two's-complement adder/subtractor.
//   Computes {C,S} = A + (B ^ {16{fSub}}) + fSub through a 16-stage ripple
//   of full adders and registers S, C, V one cycle later.
//   Ports:
//     AddSub_i_clk : clock, rising edge
//     AddSub_i_rst : synchronous active-high reset (clears S/C/V/o_valid)
//     bus          : add_sub_16b_if.slave (operands, fSub, valids, results)
module add_sub_16b
  import add_sub_16b_pkg::*;
(
  input  logic               AddSub_i_clk,
  input  logic               AddSub_i_rst,
  add_sub_16b_if.slave       bus
);

  logic [ADDSUB_W-1:0] bEff;
  logic [ADDSUB_W-1:0] sumComb;
  logic [ADDSUB_W:0]   carry;
  logic                vComb;

  logic [ADDSUB_W-1:0] sReg;
  logic                cReg;
  logic                vReg;
  logic                validReg;

  // Subtraction is A + ~B + 1: invert B and feed fSub in as the carry-in.
  assign bEff     = bus.AddSub_i_B ^ {ADDSUB_W{bus.AddSub_i_fSub}};
  assign carry[0] = bus.AddSub_i_fSub;

  for (genvar i = 0; i < ADDSUB_W; i++) begin : g_ripple
    full_adder uFa (
      .a    (bus.AddSub_i_A[i]),
      .b    (bEff[i]),
      .cin  (carry[i]),
      .s    (sumComb[i]),
      .cout (carry[i+1])
    );
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign vComb = carry[ADDSUB_W] ^ carry[ADDSUB_W-1];

  // Result registers hold their value when no operand is presented;
  // only the valid flag drops.
  always_ff @(posedge AddSub_i_clk) begin
    if (AddSub_i_rst) begin
      sReg     <= '0;
      cReg     <= 1'b0;
      vReg     <= 1'b0;
      validReg <= 1'b0;
    end else begin
      validReg <= bus.AddSub_i_valid;
      if (bus.AddSub_i_valid) begin
        sReg <= sumComb;
        cReg <= carry[ADDSUB_W];
        vReg <= vComb;
      end
    end
  end

  assign bus.AddSub_o_S     = sReg;
  assign bus.AddSub_o_C     = cReg;
  assign bus.AddSub_o_V     = vReg;
  assign bus.AddSub_o_valid = validReg;

endmodule : add_sub_16b

// File: tb/tb_add_sub_16b.sv
// tb_add_sub_16b
//   Directed bench for add_sub_16b with hand-computed expected results.
module tb_add_sub_16b;

  logic clk;
  logic rst;

  int compared   = 0;
  int mismatched = 0;

  add_sub_16b_if addSubIf ();

  add_sub_16b dut (
    .AddSub_i_clk (clk),
    .AddSub_i_rst (rst),
    .bus          (addSubIf)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Present one beat on the falling edge, let the rising edge take it,
  // then sample 1 ns after that edge.
  task automatic drive(input logic r, input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic sub);
    @(negedge clk);
    rst                     = r;
    addSubIf.AddSub_i_valid = v;
    addSubIf.AddSub_i_A     = a;
    addSubIf.AddSub_i_B     = b;
    addSubIf.AddSub_i_fSub  = sub;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOut(input string tag, input logic [15:0] s, input logic c,
                          input logic v, input logic ov);
    check({tag, ".S"},     addSubIf.AddSub_o_S, s);
    check({tag, ".C"},     {15'd0, addSubIf.AddSub_o_C}, {15'd0, c});
    check({tag, ".V"},     {15'd0, addSubIf.AddSub_o_V}, {15'd0, v});
    check({tag, ".valid"}, {15'd0, addSubIf.AddSub_o_valid}, {15'd0, ov});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst                     = 1'b1;
    addSubIf.AddSub_i_valid = 1'b0;
    addSubIf.AddSub_i_A     = '0;
    addSubIf.AddSub_i_B     = '0;
    addSubIf.AddSub_i_fSub  = 1'b0;

    // Reset held two cycles with live-looking operands.
    drive(1'b1, 1'b1, 16'hABCD, 16'h1234, 1'b0);
    drive(1'b1, 1'b1, 16'h7FFF, 16'h0001, 1'b1);
    checkOut("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    // F7F8 - 7961: no borrow; negative minus positive lands positive -> V.
    drive(1'b0, 1'b1, 16'hF7F8, 16'h7961, 1'b1);
    checkOut("sub_f7f8_7961", 16'h7E97, 1'b1, 1'b1, 1'b1);

    // E5E1 - 73A3: no borrow; sign flips the same way -> V.
    drive(1'b0, 1'b1, 16'hE5E1, 16'h73A3, 1'b1);
    checkOut("sub_e5e1_73a3", 16'h723E, 1'b1, 1'b1, 1'b1);

    // 3F1B - 46EA: borrow, no signed overflow.
    drive(1'b0, 1'b1, 16'h3F1B, 16'h46EA, 1'b1);
    checkOut("sub_borrow", 16'hF831, 1'b0, 1'b0, 1'b1);

    // FFFF + 0001: unsigned wrap with carry, no signed overflow.
    drive(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    checkOut("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);

    // 7FFF + 0001: signed overflow, no carry.
    drive(1'b0, 1'b1, 16'h7FFF, 16'h0001, 1'b0);
    checkOut("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b1);

    // A == B subtract: zero result, C=1 (no borrow).
    drive(1'b0, 1'b1, 16'h1234, 16'h1234, 1'b1);
    checkOut("sub_equal", 16'h0000, 1'b1, 1'b0, 1'b1);

    // 8000 - 0001: most-negative minus one overflows to 7FFF.
    drive(1'b0, 1'b1, 16'h8000, 16'h0001, 1'b1);
    checkOut("sub_minneg", 16'h7FFF, 1'b1, 1'b1, 1'b1);

    // Plain add, no flags.
    drive(1'b0, 1'b1, 16'h1234, 16'h4321, 1'b0);
    checkOut("add_plain", 16'h5555, 1'b0, 1'b0, 1'b1);

    // Valid gating: new operands with valid low leave S/C/V alone.
    drive(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    checkOut("gate1", 16'h5555, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1);
    checkOut("gate2", 16'h5555, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream beats a valid operand in the same cycle.
    drive(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    checkOut("pre_rst", 16'h0000, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'h7FFF, 16'h0001, 1'b0);
    checkOut("pre_rst2", 16'h8000, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    checkOut("mid_rst", 16'h0000, 1'b0, 1'b0, 1'b0);

    // First valid after reset appears one cycle later.
    drive(1'b0, 1'b1, 16'h0003, 16'h0005, 1'b1);
    checkOut("post_rst", 16'hFFFE, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    checkOut("post_rst_idle", 16'hFFFE, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_add_sub_16b
